// File: rtl/north_bus_bridge.sv
// CPU-side to north-bus bridge: four-phase req/ack handshake with a synchronized ack,
// per-phase timeout abort, sticky error flag and a completed-transfer counter.
module north_bus_bridge #(
  parameter int unsigned  TIMEOUT  = 255,
  parameter logic [15:0]  ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic        rdy,
  output logic [15:0] rdata,
  output logic        n_req,
  output logic        n_we,
  output logic [23:0] n_addr,
  output logic [15:0] n_wdata,
  input  logic        n_ack,
  input  logic [15:0] n_rdata,
  output logic        bus_err,
  output logic [15:0] xfer_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  // Timeout fires on the edge that would take the counter to TIMEOUT.
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        ack_meta, ack_s;
  logic [15:0] tcnt;
  logic        tmo;
  logic        start, capture, abort_rd, set_err;
  logic        unused_addr;

  assign unused_addr = ^addr[31:24];
  assign tmo         = (tcnt == TLIM);
  assign rdy         = (state == DONE) || (state == IDLE && !rd && !wr);

  // n_ack is asynchronous to clk; only ack_s may be used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= n_ack;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    start     = 1'b0;
    capture   = 1'b0;
    abort_rd  = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: if (rd || wr) begin
        start     = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (ack_s) begin
        capture   = ~n_we;
        state_nxt = REL;
      end else if (tmo) begin
        set_err   = 1'b1;
        abort_rd  = ~n_we;
        state_nxt = REL;
      end
      REL: if (!ack_s) begin
        state_nxt = DONE;
      end else if (tmo) begin
        set_err   = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n_req    <= 1'b0;
      n_we     <= 1'b0;
      n_addr   <= '0;
      n_wdata  <= '0;
      rdata    <= '0;
      bus_err  <= 1'b0;
      xfer_cnt <= '0;
      tcnt     <= '0;
    end else begin
      state <= state_nxt;
      n_req <= (state_nxt == REQ);

      if (state_nxt != state)
        tcnt <= '0;
      else if (state == REQ || state == REL)
        tcnt <= tcnt + 16'd1;

      if (start) begin
        n_addr  <= addr[23:0];
        n_wdata <= wdata;
        n_we    <= ~rd;
      end

      if (capture)
        rdata <= n_rdata;
      else if (abort_rd)
        rdata <= ERR_DATA;

      if (set_err)
        bus_err <= 1'b1;

      if (state == DONE)
        xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_north_bus_bridge.sv
// Directed bench for north_bus_bridge: a behavioural north-side responder with
// programmable ack delay, a request monitor, and hand-computed expectations.
module tb_north_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic        rdy, n_req, n_we, bus_err;
  logic [15:0] rdata, n_wdata, xfer_cnt;
  logic [23:0] n_addr;
  logic        n_ack = 1'b0;
  logic [15:0] n_rdata = '0;

  int          n_vec = 0;
  int          n_err = 0;

  int          ack_delay = 3;
  bit          ack_never = 1'b0;
  logic [15:0] model_rdata = '0;
  logic [23:0] ack_addr = '0;
  logic [15:0] ack_wdata = '0;
  logic [23:0] mon_addr[$];
  logic        mon_we[$];

  int          cyc, req_cyc;

  north_bus_bridge #(.TIMEOUT(8), .ERR_DATA(16'hDEAD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
    .rdy(rdy), .rdata(rdata), .n_req(n_req), .n_we(n_we), .n_addr(n_addr),
    .n_wdata(n_wdata), .n_ack(n_ack), .n_rdata(n_rdata),
    .bus_err(bus_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // North responder: acks ack_delay cycles after n_req rises, releases after n_req falls.
  initial forever begin
    wait (n_req === 1'b1);
    repeat (ack_delay) @(posedge clk);
    if (!ack_never) begin
      #1;
      ack_addr  = n_addr;
      ack_wdata = n_wdata;
      n_rdata   = model_rdata;
      n_ack     = 1'b1;
      wait (n_req === 1'b0);
      #1 n_ack = 1'b0;
    end else begin
      wait (n_req === 1'b0);
    end
  end

  initial forever begin
    @(posedge n_req);
    #1;
    mon_addr.push_back(n_addr);
    mon_we.push_back(n_we);
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
  endtask

  // Polls on falling edges until rdy; counts cycles and cycles with n_req high.
  task automatic wait_done(output int cycles, output int req_cycles);
    cycles = 0;
    req_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (n_req) req_cycles++;
    end while (!rdy && cycles < 200);
    check("done_seen", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_n_req", {31'd0, n_req}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

    // Read with 3-cycle north delay.
    ack_delay = 3; model_rdata = 16'hBEEF;
    drive(1'b1, 1'b0, 32'h0000_1234, 16'h0);
    wait_done(cyc, req_cyc);
    check("rd_req_cycles", req_cyc, 32'd6);
    check("rd_rdata", {16'd0, rdata}, 32'h0000_BEEF);
    check("rd_n_addr", {8'd0, n_addr}, 32'h0000_1234);
    check("rd_n_we", {31'd0, n_we}, 32'd0);
    rd = 1'b0;
    @(negedge clk);
    check("rd_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);
    check("rd_ack_addr", {8'd0, ack_addr}, 32'h0000_1234);

    // Immediate ack: request edge plus six cycles to DONE.
    ack_delay = 0; model_rdata = 16'h1357;
    drive(1'b1, 1'b0, 32'h0000_0030, 16'h0);
    wait_done(cyc, req_cyc);
    check("lat_cycles", cyc, 32'd7);
    check("lat_rdata", {16'd0, rdata}, 32'h0000_1357);
    rd = 1'b0;

    // Write.
    ack_delay = 2;
    drive(1'b0, 1'b1, 32'h0000_0010, 16'hA5A5);
    wait_done(cyc, req_cyc);
    check("wr_n_we", {31'd0, n_we}, 32'd1);
    check("wr_n_wdata", {16'd0, n_wdata}, 32'h0000_A5A5);
    check("wr_ack_wdata", {16'd0, ack_wdata}, 32'h0000_A5A5);
    check("wr_ack_addr", {8'd0, ack_addr}, 32'h0000_0010);
    check("wr_bus_err", {31'd0, bus_err}, 32'd0);
    wr = 1'b0;
    @(negedge clk);
    check("wr_rdy_idle", {31'd0, rdy}, 32'd1);
    check("wr_xfer_cnt", {16'd0, xfer_cnt}, 32'd3);
    check("wr_rdata_held", {16'd0, rdata}, 32'h0000_1357);

    // Back-to-back reads with rd held across DONE.
    ack_delay = 1; model_rdata = 16'h2222;
    mon_addr.delete(); mon_we.delete();
    drive(1'b1, 1'b0, 32'h0000_0020, 16'h0);
    wait_done(cyc, req_cyc);
    check("b2b_rdata0", {16'd0, rdata}, 32'h0000_2222);
    addr = 32'h0000_0021; model_rdata = 16'h3333;
    @(negedge clk);
    check("b2b_done_one_cycle", {31'd0, rdy}, 32'd0);
    wait_done(cyc, req_cyc);
    check("b2b_rdata1", {16'd0, rdata}, 32'h0000_3333);
    rd = 1'b0;
    @(negedge clk);
    check("b2b_xfer_cnt", {16'd0, xfer_cnt}, 32'd5);
    check("b2b_mon_count", mon_addr.size(), 32'd2);
    check("b2b_addr0", {8'd0, mon_addr[0]}, 32'h0000_0020);
    check("b2b_addr1", {8'd0, mon_addr[1]}, 32'h0000_0021);

    // Never-acking north side: REQ abort after 8 cycles.
    ack_never = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0040, 16'h0);
    wait_done(cyc, req_cyc);
    check("tmo_req_cycles", req_cyc, 32'd8);
    check("tmo_total_cycles", cyc, 32'd10);
    check("tmo_rdata", {16'd0, rdata}, 32'h0000_DEAD);
    check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    rd = 1'b0; ack_never = 1'b0; ack_delay = 1;
    drive(1'b0, 1'b1, 32'h0000_0050, 16'h1111);
    wait_done(cyc, req_cyc);
    wr = 1'b0;
    @(negedge clk);
    check("tmo_err_sticky", {31'd0, bus_err}, 32'd1);
    check("tmo_rdata_held", {16'd0, rdata}, 32'h0000_DEAD);
    check("tmo_xfer_cnt", {16'd0, xfer_cnt}, 32'd7);

    // Reset while in REQ with n_ack high.
    ack_delay = 0;
    drive(1'b1, 1'b0, 32'h0000_0060, 16'h7777);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_n_req", {31'd0, n_req}, 32'd0);
    check("mid_rst_n_addr", {8'd0, n_addr}, 32'd0);
    check("mid_rst_n_we", {31'd0, n_we}, 32'd0);
    check("mid_rst_n_wdata", {16'd0, n_wdata}, 32'd0);
    check("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("mid_rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_rdy", {31'd0, rdy}, 32'd1);
    repeat (3) @(negedge clk);

    // rd+wr together performs a read; counter wraps from FFFF.
    ack_delay = 1; model_rdata = 16'h4444;
    mon_we.delete(); mon_addr.delete();
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    #1 release dut.xfer_cnt;
    drive(1'b1, 1'b1, 32'h0000_0070, 16'h9999);
    wait_done(cyc, req_cyc);
    check("both_n_we", {31'd0, n_we}, 32'd0);
    check("both_mon_we", {31'd0, mon_we[0]}, 32'd0);
    check("both_rdata", {16'd0, rdata}, 32'h0000_4444);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("wrap_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
